// File: rtl/lif_spike_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lif_spike_arbiter
// Description : Address-event encoder/arbiter for the LIF neuron layer.
//               Single-cycle spike pulses are latched into per-neuron pending
//               flags. The flags are round-robin arbitrated onto one
//               valid/ready event channel that carries the neuron index.
//               Spikes that arrive while their neuron is already pending
//               (and not being accepted) are dropped and counted.
// Ports       : clk, rst_n (sync, active-low), ena (freezes intake/grants)
//               spike_in[N_IN]   spike pulses sampled at posedge
//               ev_valid/ev_ready/ev_addr/ev_ts  event channel
//               pending[N_IN]    registered pending flags
//               drop_cnt[8]      saturating dropped-spike count
//               overflow         sticky, at least one spike dropped
// Options     : define LIF_ARB_TIMESTAMP_EN to add a free-running TS_W-bit
//               timestamp captured per neuron and returned on ev_ts;
//               without it ev_ts is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_spike_arbiter #(
    parameter int N_IN   = 8,
    parameter int ADDR_W = 3,
    parameter int TS_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [N_IN-1:0]   spike_in,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [TS_W-1:0]   ev_ts,
    output logic [N_IN-1:0]   pending,
    output logic [7:0]        drop_cnt,
    output logic              overflow
);

    localparam int c_NPOW  = 1 << ADDR_W;
    localparam int c_CNT_W = $clog2(N_IN + 1);
    localparam int c_SUM_W = ((c_CNT_W > 8) ? c_CNT_W : 8) + 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [N_IN-1:0]     r_pending;
    logic                r_ev_valid;
    logic [ADDR_W-1:0]   r_ev_addr;
    logic [TS_W-1:0]     r_ev_ts;
    logic [7:0]          r_drop_cnt;
    logic                r_overflow;

    logic                w_accept;
    logic [N_IN-1:0]     w_acc_onehot;
    logic [N_IN-1:0]     w_spike;
    logic [N_IN-1:0]     w_drop;
    logic [N_IN-1:0]     w_capture;
    logic [c_CNT_W-1:0]  w_drop_num;
    logic [c_SUM_W-1:0]  w_drop_sum;
    logic [ADDR_W-1:0]   w_next_ptr;
    logic [ADDR_W-1:0]   w_start;
    logic [c_NPOW-1:0]   w_cand_ext;
    logic [ADDR_W:0]     w_idx;
    logic                w_gnt_found;
    logic [ADDR_W-1:0]   w_gnt_idx;
    logic [TS_W-1:0]     w_ts_sel;

    assign w_accept   = r_ev_valid & ev_ready;
    assign w_spike    = ena ? spike_in : '0;
    assign w_next_ptr = (r_ev_addr == ADDR_W'(N_IN - 1)) ? '0 : r_ev_addr + 1'b1;

    // A spike coinciding with acceptance of its own event re-arms the flag
    // instead of being dropped.
    always_comb begin
        w_acc_onehot = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_acc_onehot[i] = w_accept && (r_ev_addr == ADDR_W'(i));
        end
    end

    assign w_drop    = w_spike & r_pending & ~w_acc_onehot;
    assign w_capture = w_spike & (~r_pending | w_acc_onehot);

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_drop_num = w_drop_num + c_CNT_W'(w_drop[i]);
        end
    end

    assign w_drop_sum = c_SUM_W'(r_drop_cnt) + c_SUM_W'(w_drop_num);

    // Grant search. While presenting, the search starts after the event being
    // accepted and excludes it, so only pending flags registered before this
    // edge are candidates.
    assign w_start    = (r_state == ST_PRESENT) ? w_next_ptr : r_ptr;
    assign w_cand_ext = c_NPOW'((r_state == ST_PRESENT) ? (r_pending & ~w_acc_onehot)
                                                        : r_pending);

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_idx       = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_idx = {1'b0, w_start} + (ADDR_W + 1)'(k);
            if (w_idx >= (ADDR_W + 1)'(N_IN)) begin
                w_idx = w_idx - (ADDR_W + 1)'(N_IN);
            end
            if (!w_gnt_found && w_cand_ext[w_idx[ADDR_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_idx[ADDR_W-1:0];
            end
        end
    end

`ifdef LIF_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_reg [N_IN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_ts_reg[i] <= '0;
            end
        end else begin
            if (ena) begin
                r_ts_cnt <= r_ts_cnt + 1'b1;
            end
            for (int i = 0; i < N_IN; i++) begin
                if (w_capture[i]) begin
                    r_ts_reg[i] <= r_ts_cnt;
                end
            end
        end
    end

    assign w_ts_sel = r_ts_reg[w_gnt_idx];
`else
    assign w_ts_sel = '0;
`endif

    // Intake and drop accounting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending <= w_spike | (r_pending & ~w_acc_onehot);
            if (|w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= (w_drop_sum > c_SUM_W'(255)) ? 8'hFF : w_drop_sum[7:0];
            end
        end
    end

    // Output FSM. A presented event is never retracted; only acceptance
    // moves it on, even with ena low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_ev_valid <= 1'b0;
            r_ev_addr  <= '0;
            r_ev_ts    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ena && w_gnt_found) begin
                        r_ev_valid <= 1'b1;
                        r_ev_addr  <= w_gnt_idx;
                        r_ev_ts    <= w_ts_sel;
                        r_state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ev_ready) begin
                        r_ptr <= w_next_ptr;
                        if (ena && w_gnt_found) begin
                            r_ev_addr <= w_gnt_idx;
                            r_ev_ts   <= w_ts_sel;
                        end else begin
                            r_ev_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_ev_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_addr  = r_ev_addr;
    assign ev_ts    = r_ev_ts;
    assign pending  = r_pending;
    assign drop_cnt = r_drop_cnt;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lif_spike_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_spike_arbiter
// Description : Directed self-checking bench for lif_spike_arbiter with a
//               per-cycle reference model and hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lif_spike_arbiter;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       ev_ready = 1'b0;
    logic [7:0] spike_in = '0;
    logic       ev_valid;
    logic [2:0] ev_addr;
    logic [7:0] ev_ts;
    logic [7:0] pending;
    logic [7:0] drop_cnt;
    logic       overflow;

    lif_spike_arbiter #(.N_IN(8), .ADDR_W(3), .TS_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .spike_in (spike_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_addr  (ev_addr),
        .ev_ts    (ev_ts),
        .pending  (pending),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    int acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_pend;
    bit         m_valid;
    int         m_addr, m_ptr, m_drop, m_cnt, m_ts;
    bit         m_ovf;
    int         m_tsr[N];

    function automatic int pick(input logic [7:0] c, input int s);
        for (int k = 0; k < N; k++) begin
            if (c[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit         acc;
        int         acc_idx, g, nd;
        logic [7:0] p, cand;
        if (!rst_n) begin
            m_pend = '0; m_valid = 0; m_addr = 0; m_ptr = 0;
            m_drop = 0; m_ovf = 0; m_cnt = 0; m_ts = 0;
            for (int i = 0; i < N; i++) m_tsr[i] = 0;
        end else begin
            acc     = m_valid && ev_ready;
            acc_idx = m_addr;
            p       = m_pend;
            // grant decisions use flags as they stood before this edge
            if (acc) begin
                m_ptr = (acc_idx + 1) % N;
                cand = p;
                cand[acc_idx] = 1'b0;
                g = ena ? pick(cand, m_ptr) : -1;
                if (g >= 0) begin
                    m_addr = g; m_ts = m_tsr[g];
                end else begin
                    m_valid = 0;
                end
            end else if (!m_valid && ena && p != 0) begin
                g = pick(p, m_ptr);
                m_valid = 1; m_addr = g; m_ts = m_tsr[g];
            end
            nd = 0;
            for (int i = 0; i < N; i++) begin
                if (ena && spike_in[i]) begin
                    if (p[i] && !(acc && acc_idx == i)) nd++;
`ifdef LIF_ARB_TIMESTAMP_EN
                    else m_tsr[i] = m_cnt;
`endif
                    m_pend[i] = 1'b1;
                end else if (acc && acc_idx == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (nd > 0) m_ovf = 1;
            m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
`ifdef LIF_ARB_TIMESTAMP_EN
            if (ena) m_cnt = (m_cnt + 1) % 256;
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("ev_valid", ev_valid, m_valid);
            chk("pending", pending, m_pend);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("overflow", overflow, m_ovf);
            if (m_valid) begin
                chk("ev_addr", ev_addr, m_addr);
                chk("ev_ts", ev_ts, m_ts);
            end
            if (ev_valid && ev_ready) acc_q.push_back(int'(ev_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with toggling spikes
        ena = 1'b1;
        spike_in = 8'hFF; tick(); started = 1;
        spike_in = 8'h00; tick();
        spike_in = 8'hAA; tick();
        chk("rst_valid", ev_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", ev_addr, 0);
        chk("rst_ts", ev_ts, 0);

        // first event after reset
        rst_n = 1'b1; spike_in = 8'h01; ev_ready = 1'b1; tick();
        spike_in = 8'h00;
        chk("first_pend", pending, 8'h01);
        chk("first_valid0", ev_valid, 0);
        tick();
        chk("first_valid", ev_valid, 1);
        chk("first_addr", ev_addr, 0);
        tick();
        chk("first_done", ev_valid, 0);

        // single spike on neuron 5
        spike_in = 8'h20; tick(); spike_in = 8'h00;
        chk("single_pend", pending, 8'h20);
        chk("single_valid0", ev_valid, 0);
        tick();
        chk("single_valid", ev_valid, 1);
        chk("single_addr", ev_addr, 5);
        tick();
        chk("single_idle", ev_valid, 0);
        chk("single_clear", pending, 0);

        // bring pointer back to 0 via neuron 7
        spike_in = 8'h80; tick(); spike_in = 8'h00; tick(); tick();

        // burst of all eight
        acc_q.delete();
        spike_in = 8'hFF; tick(); spike_in = 8'h00;
        repeat (9) tick();
        chk("burst_count", acc_q.size(), 8);
        for (int i = 0; i < 8 && i < acc_q.size(); i++) chk("burst_order", acc_q[i], i);
        chk("burst_idle", ev_valid, 0);
        chk("burst_drop", drop_cnt, 0);
        chk("burst_ovf", overflow, 0);

        // backpressure and drops on neuron 2
        acc_q.delete();
        ev_ready = 1'b0; spike_in = 8'h04; tick();
        tick(); chk("bp_valid", ev_valid, 1); chk("bp_addr_a", ev_addr, 2);
        tick(); chk("bp_addr_b", ev_addr, 2);
        tick(); chk("bp_addr_c", ev_addr, 2);
        spike_in = 8'h00;
        chk("bp_drop", drop_cnt, 3);
        chk("bp_ovf", overflow, 1);
        ev_ready = 1'b1; tick();
        chk("bp_clear", pending, 0);
        chk("bp_idle", ev_valid, 0);
        chk("bp_accepts", acc_q.size(), 1);

        // round robin with coincident spike on the accept edge
        acc_q.delete();
        ev_ready = 1'b0; spike_in = 8'h08; tick();
        spike_in = 8'h00; tick();
        spike_in = 8'h42; tick();
        spike_in = 8'h00; ev_ready = 1'b1; tick();
        chk("rr_addr6", ev_addr, 6);
        spike_in = 8'h40; tick();
        spike_in = 8'h00;
        chk("rr_addr1", ev_addr, 1);
        chk("rr_pend", pending, 8'h42);
        tick(); chk("rr_addr6b", ev_addr, 6);
        tick(); tick();
        chk("rr_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            chk("rr_o0", acc_q[0], 3); chk("rr_o1", acc_q[1], 6);
            chk("rr_o2", acc_q[2], 1); chk("rr_o3", acc_q[3], 6);
        end
        chk("rr_drop", drop_cnt, 3);

        // enable low: intake frozen, presented event held
        ena = 1'b0; spike_in = 8'hFF; tick(); tick(); spike_in = 8'h00;
        chk("ena_pend", pending, 0);
        chk("ena_drop", drop_cnt, 3);
        ena = 1'b1; ev_ready = 1'b0; spike_in = 8'h01; tick();
        spike_in = 8'h00; tick();
        chk("ena_valid", ev_valid, 1); chk("ena_addr", ev_addr, 0);
        ena = 1'b0; tick(); tick();
        chk("ena_hold", ev_valid, 1); chk("ena_hold_addr", ev_addr, 0);
        ev_ready = 1'b1; tick();
        chk("ena_acc_idle", ev_valid, 0); chk("ena_acc_pend", pending, 0);
        ena = 1'b1;

        // eight drops on one edge, then saturation
        ev_ready = 1'b0; spike_in = 8'hFF; tick(); tick();
        chk("multi_drop", drop_cnt, 11);
        repeat (31) tick();
        chk("sat_drop", drop_cnt, 255);
        chk("sat_ovf", overflow, 1);
        spike_in = 8'h00; ev_ready = 1'b1;
        repeat (12) tick();
        chk("drain_pend", pending, 0);
        chk("drain_idle", ev_valid, 0);

`ifdef LIF_ARB_TIMESTAMP_EN
        begin
            int n;
            n = 0;
            ev_ready = 1'b0;
            while (m_cnt != 10 && n < 600) begin tick(); n++; end
            chk("ts_align_timeout", (n < 600), 1);
            spike_in = 8'h10; tick(); spike_in = 8'h00;
            repeat (5) tick();
            chk("ts_valid", ev_valid, 1);
            chk("ts_addr", ev_addr, 4);
            chk("ts_value", ev_ts, 10);
            ev_ready = 1'b1; tick();
            chk("ts_done", ev_valid, 0);
            // run across a counter wrap with sparse spikes
            for (int c = 0; c < 270; c++) begin
                spike_in = ((c % 16) == 0) ? 8'(1 << (c % 8)) : 8'h00;
                tick();
            end
            spike_in = 8'h00;
        end
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
